// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// First-word-fall-through queue of {PC, instruction} pairs that sits between
// the instruction fetch unit and decode. Entries leave strictly in arrival
// order. A pre-decode legality flag is computed for the head entry.
//
// Ports
//   clock        single clock, all state changes on its rising edge
//   reset        synchronous, active-high reset
//   in_valid     fetch side presents an instruction
//   in_ready     queue can accept an instruction this cycle
//   in_pc        PC of the presented instruction (64 bits)
//   in_instr     32-bit instruction word
//   flush        discard every queued entry (redirect)
//   out_valid    head entry is valid for decode
//   out_ready    decode consumes the head entry this cycle
//   out_pc       PC of the head entry (0 when empty)
//   out_instr    instruction of the head entry (NOP 0x00000013 when empty)
//   out_illegal  head entry fails the pre-decode legality check
//   count        number of occupied entries
// ---------------------------------------------------------------------------
module instr_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [63:0]                in_pc,
   input  logic [31:0]                in_instr,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [63:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Entry storage is never reset: an entry is only ever read after it
   // has been written, and the outputs are muxed to constants when empty.
   // The head must be visible in the same cycle it becomes valid, so the
   // read is combinational (small LUT-RAM style array).
   logic [63:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0] count_reg,  count_next;

   logic do_push;
   logic do_pop;
   logic [31:0] head_instr;

   // Readiness looks only at occupancy, never at out_ready: a full queue
   // refuses a push even if the head leaves in the same cycle.
   assign in_ready  = (count_reg < CW'(DEPTH)) && !reset;
   assign out_valid = (count_reg != '0);
   assign count     = count_reg;

   // Flush and reset both override any transfer in the same cycle.
   assign do_push = in_valid && in_ready && !flush;
   assign do_pop  = out_valid && out_ready && !flush && !reset;

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is natural overflow.
         if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end

   // One write-enable per entry so each slot maps to a simple enabled register.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clock) begin
            if (do_push && (wr_ptr_reg == PW'(gi))) begin
               pc_mem[gi]    <= in_pc;
               instr_mem[gi] <= in_instr;
            end
         end
      end
   endgenerate

   assign head_instr = instr_mem[rd_ptr_reg];

   always_comb begin
      out_pc      = 64'd0;
      out_instr   = NOP_INSTR;
      out_illegal = 1'b0;
      if (out_valid) begin
         out_pc    = pc_mem[rd_ptr_reg];
         out_instr = head_instr;
         // Compressed encodings and the all-zero / all-one words are
         // rejected; all-ones has low bits 11, so it needs its own test.
         out_illegal = (head_instr[1:0] != 2'b11) ||
                       (head_instr == 32'h0000_0000) ||
                       (head_instr == 32'hFFFF_FFFF);
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue
// Directed self-checking bench for instr_queue (DEPTH = 4). Inputs change
// 1 time unit after the rising edge; outputs are checked there too, so the
// values seen are the settled post-edge state plus current inputs.
// ---------------------------------------------------------------------------
module tb_instr_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_illegal;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   instr_queue #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_illegal (out_illegal),
      .count       (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [31:0] legal_vec [4];
   logic        legal_exp [4];

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_count",     64'(count),     64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'h13);
      check("rst_out_pc",    out_pc,         64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      reset = 1'b0;
      #1;
      check("rel_in_ready",  64'(in_ready),  64'd1);

      // ---------------- basic flow ----------------
      push(64'h1000, 32'h0050_0093);
      check("basic_valid",   64'(out_valid),   64'd1);
      check("basic_pc",      out_pc,           64'h1000);
      check("basic_instr",   64'(out_instr),   64'h0050_0093);
      check("basic_illegal", 64'(out_illegal), 64'd0);
      check("basic_count",   64'(count),       64'd1);
      pop();
      check("basic_empty",   64'(count),       64'd0);

      // ---------------- fill / full ----------------
      for (int i = 0; i < 4; i++) begin
         push(64'h1000 + 64'(4 * i), 32'h0000_0013);
      end
      check("full_count",    64'(count),    64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      // 5th push with a simultaneous pop: the pop is taken, the push is not.
      check("drain_pc0", out_pc, 64'h1000);
      in_valid  = 1'b1;
      in_pc     = 64'h1010;
      in_instr  = 32'h0000_0013;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("refuse_count", 64'(count), 64'd3);
      for (int i = 1; i < 4; i++) begin
         check($sformatf("drain_pc%0d", i), out_pc, 64'h1000 + 64'(4 * i));
         pop();
      end
      check("drain_count", 64'(count),     64'd0);
      check("drain_instr", 64'(out_instr), 64'h13);
      check("drain_valid", 64'(out_valid), 64'd0);

      // ---------------- wrap-around ----------------
      push(64'h4000, 32'h0000_0013);
      push(64'h4004, 32'h0000_0013);
      check("wrap_start", 64'(count), 64'd2);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("wrap_pc%0d", k), out_pc, 64'h4000 + 64'(4 * k));
         in_valid  = 1'b1;
         in_pc     = 64'h4008 + 64'(4 * k);
         in_instr  = 32'h0000_0013;
         out_ready = 1'b1;
         tick();
         check($sformatf("wrap_cnt%0d", k), 64'(count), 64'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("wrap_tail0", out_pc, 64'h4028);
      pop();
      check("wrap_tail1", out_pc, 64'h402C);
      pop();
      check("wrap_end", 64'(count), 64'd0);

      // ---------------- flush ----------------
      for (int i = 0; i < 3; i++) begin
         push(64'h5000 + 64'(4 * i), 32'h0000_0013);
      end
      check("flush_pre", 64'(count), 64'd3);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_pc     = 64'h2000;
      in_instr  = 32'h0000_0013;
      out_ready = 1'b1;
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("flush_count", 64'(count),     64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_pc",    out_pc,         64'd0);
      push(64'h3000, 32'h0000_0013);
      check("post_flush_valid", 64'(out_valid), 64'd1);
      check("post_flush_pc",    out_pc,         64'h3000);
      check("post_flush_count", 64'(count),     64'd1);
      pop();

      // ---------------- legality ----------------
      legal_vec[0] = 32'h0000_0000; legal_exp[0] = 1'b1;
      legal_vec[1] = 32'hFFFF_FFFF; legal_exp[1] = 1'b1;
      legal_vec[2] = 32'h0000_4501; legal_exp[2] = 1'b1;
      legal_vec[3] = 32'h0000_0013; legal_exp[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(64'h7000 + 64'(4 * i), legal_vec[i]);
         check($sformatf("illegal_%08h", legal_vec[i]), 64'(out_illegal), 64'(legal_exp[i]));
         check($sformatf("instr_%08h", legal_vec[i]), 64'(out_instr), 64'(legal_vec[i]));
         pop();
      end

      // ---------------- reset mid-operation ----------------
      push(64'h6000, 32'h0000_0013);
      push(64'h6004, 32'h0000_0013);
      check("mid_pre", 64'(count), 64'd2);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_pc    = 64'h6008;
      in_instr = 32'h0000_0013;
      #1;
      check("mid_in_ready_rst", 64'(in_ready), 64'd0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_count",    64'(count),     64'd0);
      check("mid_valid",    64'(out_valid), 64'd0);
      check("mid_in_ready", 64'(in_ready),  64'd1);
      check("mid_out_pc",   out_pc,         64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4: number of queue entries; a power of two, at least 2.
REQ-002 SHALL provide port CLOCK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port IN_VALID  input  1  fetch side presents an instruction.
REQ-005 SHALL provide port IN_READY  output  1  queue can accept an instruction this cycle.
REQ-006 SHALL provide port IN_PC  input  64  PC of the presented instruction.
REQ-007 SHALL provide port IN_INSTR  input  32  32-bit instruction word from the IFU.
REQ-008 SHALL provide port FLUSH  input  1  discard all queued entries (redirect).
REQ-009 SHALL provide port OUT_VALID  output  1  head entry is valid for decode.
REQ-010 SHALL provide port OUT_READY  input  1  decode consumes the head entry this cycle.
REQ-011 SHALL provide port OUT_PC  output  64  PC of the head entry.
REQ-012 SHALL provide port OUT_INSTR  output  32  instruction of the head entry.
REQ-013 SHALL provide port OUT_ILLEGAL  output  1  head entry fails pre-decode legality check.
REQ-014 SHALL provide port COUNT  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL operate as a first-word-fall-through FIFO of {PC, INSTR} pairs, strictly in arrival order.
REQ-016 SHALL enqueue on a rising edge where IN_VALID and IN_READY are both high; SHALL dequeue where OUT_VALID and OUT_READY are both high.
REQ-017 SHALL drive IN_READY = (COUNT < DEPTH) and not RESET; IN_READY SHALL NOT depend on OUT_READY, so a full queue refuses a push even when a pop occurs in the same cycle.
REQ-018 SHALL drive OUT_VALID = (COUNT != 0), as a function of registered state only.
REQ-019 SHALL give enqueue-to-output latency of 1 cycle: a push into an empty queue makes OUT_VALID high, with that entry at the head, in the following cycle.
REQ-020 On a simultaneous push and pop with 0 < COUNT < DEPTH, SHALL keep COUNT unchanged and advance both read and write pointers.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-022 A pop while empty and a push while full SHALL be ignored, with no state change.
REQ-023 When OUT_VALID is low, SHALL drive OUT_INSTR = 32'h00000013 (canonical NOP), OUT_PC = 0 and OUT_ILLEGAL = 0.
REQ-024 When OUT_VALID is high, SHALL assert OUT_ILLEGAL if OUT_INSTR[1:0] != 2'b11, or OUT_INSTR == 32'h00000000, or OUT_INSTR == 32'hFFFFFFFF.
REQ-025 FLUSH high at a rising edge SHALL set COUNT = 0 and both pointers = 0.
REQ-026 A push in the same cycle as FLUSH SHALL be discarded, and a pop in that cycle SHALL have no further effect.
REQ-027 SHALL give priority RESET > FLUSH > push/pop.
REQ-028 SHALL keep every output free of X after the first reset edge; entry storage need not be reset.

Reset
REQ-029 On a rising edge with RESET high, SHALL set COUNT = 0, both pointers = 0, OUT_VALID = 0, OUT_INSTR = 32'h00000013 and OUT_PC = 0.
REQ-030 While RESET is high, SHALL hold IN_READY = 0 and ignore IN_VALID, OUT_READY and FLUSH.
REQ-031 Reset asserted mid-operation SHALL discard all entries at the next edge; IN_READY SHALL return high in the first cycle after RESET falls.

Verification
REQ-032 Bench SHALL cover basic flow: after reset, push PC=0x1000 INSTR=0x00500093 -> next cycle OUT_VALID=1, OUT_PC=0x1000, OUT_INSTR=0x00500093, OUT_ILLEGAL=0, COUNT=1.
REQ-033 Bench SHALL cover fill/full: 4 pushes with OUT_READY=0 -> COUNT=4, IN_READY=0; a 5th push with OUT_READY=1 is refused; then drain 4 pops in PC order 0x1000, 0x1004, 0x1008, 0x100C -> COUNT=0, OUT_INSTR=0x00000013.
REQ-034 Bench SHALL cover wrap-around: 10 cycles of continuous push+pop at COUNT=2 -> COUNT stays 2; output PC sequence is contiguous with no gaps or repeats across the pointer wrap.
REQ-035 Bench SHALL cover flush: COUNT=3, FLUSH=1 with a simultaneous push of PC=0x2000 -> next cycle COUNT=0, OUT_VALID=0; the next accepted push of PC=0x3000 appears at the head one cycle later.
REQ-036 Bench SHALL cover the legality check: push INSTR=0x00000000, 0xFFFFFFFF and 0x00004501 -> each shows OUT_ILLEGAL=1 at the head; INSTR=0x00000013 -> OUT_ILLEGAL=0.
REQ-037 Bench SHALL cover reset mid-operation: COUNT=2, RESET=1 for one cycle together with a push -> COUNT=0, OUT_VALID=0, the push is dropped, IN_READY=1 on the cycle after RESET falls.
